// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: 2-flop synchronizer, per-lane stability FSM, registered level and edge outputs.
// Optional sticky event register (i_ack / o_event) when SW_DEBOUNCE_STICKY_EN is defined.
module sw_debounce #(
    parameter int NB_SW           = 4,
    parameter int NB_DEBOUNCE     = 20,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
`ifdef SW_DEBOUNCE_STICKY_EN
    input  logic             i_ack,
    output logic [NB_SW-1:0] o_event,
`endif
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall,
    output logic             o_changed
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } lane_state_t;

    localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

    logic [NB_SW-1:0]       sync1_q;
    logic [NB_SW-1:0]       sw_s_q;
    lane_state_t            state_q [NB_SW];
    lane_state_t            state_d [NB_SW];
    logic [NB_DEBOUNCE-1:0] cnt_q   [NB_SW];
    logic [NB_DEBOUNCE-1:0] cnt_d   [NB_SW];
    logic [NB_SW-1:0]       lvl_q;
    logic [NB_SW-1:0]       lvl_d;
    logic [NB_SW-1:0]       sw_q;
    logic [NB_SW-1:0]       rise_q;
    logic [NB_SW-1:0]       fall_q;
    logic                   changed_q;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sw_s_q  <= '0;
        end else begin
            sync1_q <= i_sw;
            sw_s_q  <= sync1_q;
        end
    end

    // Each lane compares the synchronized input against its accepted level lvl_q.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < NB_SW; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                ST_STABLE: begin
                    if (sw_s_q[i] != lvl_q[i]) begin
                        state_d[i] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (sw_s_q[i] == lvl_q[i]) begin
                        state_d[i] = ST_STABLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        lvl_d[i]   = sw_s_q[i];
                        state_d[i] = ST_STABLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = ST_STABLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NB_SW; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            lvl_q <= '0;
        end else begin
            for (int i = 0; i < NB_SW; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            lvl_q <= lvl_d;
        end
    end

    // Outputs leave from flops one stage after the lane decision; edges come from lvl_q vs its delayed copy.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sw_q      <= lvl_q;
            rise_q    <= lvl_q & ~sw_q;
            fall_q    <= ~lvl_q & sw_q;
            changed_q <= |(lvl_q ^ sw_q);
        end
    end

    assign o_sw      = sw_q;
    assign o_sw_rise = rise_q;
    assign o_sw_fall = fall_q;
    assign o_changed = changed_q;

`ifdef SW_DEBOUNCE_STICKY_EN
    logic [NB_SW-1:0] event_q;

    // Set terms are OR-ed after the acknowledge clear so a coincident edge survives.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            event_q <= '0;
        end else begin
            event_q <= (event_q & ~{NB_SW{i_ack}}) | rise_q | fall_q;
        end
    end

    assign o_event = event_q;
`endif

endmodule
